// File: rtl/seg7_scan_driver.sv
// Multiplexed N-digit 7-segment scan driver with frame snapshot, hex mode,
// leading-zero blanking, decimal points and an anti-ghost dead cycle on each digit change.
module seg7_scan_driver #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SCAN_DIV   = 100000,
  parameter int unsigned CNT_W      = 17,
  localparam int unsigned IDX_W     = $clog2(NUM_DIGITS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    hex_en,
  input  logic                    blank_lz,
  input  logic                    enable,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              segment,
  output logic                    dp,
  output logic [IDX_W-1:0]        scan_idx
);

  logic [CNT_W-1:0]        r_cnt;
  logic [IDX_W-1:0]        r_idx;
  logic [4*NUM_DIGITS-1:0] r_snap_dig;
  logic [NUM_DIGITS-1:0]   r_snap_dp;
  logic                    r_snap_hex;
  logic                    r_snap_blz;
  logic                    r_first;
  logic                    r_was_en;
  logic [NUM_DIGITS-1:0]   r_an;
  logic [6:0]              r_seg;
  logic                    r_dp;

  logic                    w_tick;
  logic                    w_wrap;
  logic                    w_cap;
  logic [IDX_W-1:0]        w_idx_nxt;
  logic [4*NUM_DIGITS-1:0] w_dig;
  logic [NUM_DIGITS-1:0]   w_dpv;
  logic                    w_hex;
  logic                    w_blz;
  logic [NUM_DIGITS-1:0]   w_blank;
  logic [3:0]              w_val;
  logic                    w_lit;
  logic [6:0]              w_seg_nxt;
  logic [NUM_DIGITS-1:0]   w_an_nxt;

  function automatic logic [6:0] decode(input logic [3:0] v, input logic hex);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    if (v > 4'd9 && !hex) s = 7'b1111111;
    return s;
  endfunction

  assign w_tick    = (r_cnt == CNT_W'(SCAN_DIV - 1));
  assign w_wrap    = w_tick && (r_idx == IDX_W'(NUM_DIGITS - 1));
  assign w_idx_nxt = w_wrap ? '0 : (w_tick ? r_idx + IDX_W'(1) : r_idx);
  // The frame about to start decodes from the fresh capture, not the stale snapshot.
  assign w_cap     = r_first || w_wrap;
  assign w_dig     = w_cap ? digits   : r_snap_dig;
  assign w_dpv     = w_cap ? dp_in    : r_snap_dp;
  assign w_hex     = w_cap ? hex_en   : r_snap_hex;
  assign w_blz     = w_cap ? blank_lz : r_snap_blz;

  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    w_blank    = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above && (w_dig[4*i +: 4] == 4'd0);
      w_blank[i] = zero_above && w_blz && (i != 0);
    end
  end

  assign w_val     = w_dig[{w_idx_nxt, 2'b00} +: 4];
  assign w_seg_nxt = w_blank[w_idx_nxt] ? 7'b1111111 : decode(w_val, w_hex);
  assign w_lit     = !w_blank[w_idx_nxt] || w_dpv[w_idx_nxt];
  assign w_an_nxt  = (w_tick || !r_was_en || !w_lit) ? '1
                   : ~(NUM_DIGITS'(1) << w_idx_nxt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_idx      <= '0;
      r_snap_dig <= '0;
      r_snap_dp  <= '0;
      r_snap_hex <= 1'b0;
      r_snap_blz <= 1'b0;
      r_first    <= 1'b1;
      r_was_en   <= 1'b1;
      r_an       <= '1;
      r_seg      <= 7'b1111111;
      r_dp       <= 1'b1;
    end else if (!enable) begin
      r_an     <= '1;
      r_seg    <= 7'b1111111;
      r_dp     <= 1'b1;
      r_was_en <= 1'b0;
    end else begin
      r_cnt    <= w_tick ? '0 : r_cnt + CNT_W'(1);
      r_idx    <= w_idx_nxt;
      r_first  <= 1'b0;
      r_was_en <= 1'b1;
      if (w_cap) begin
        r_snap_dig <= digits;
        r_snap_dp  <= dp_in;
        r_snap_hex <= hex_en;
        r_snap_blz <= blank_lz;
      end
      r_an  <= w_an_nxt;
      r_seg <= w_seg_nxt;
      r_dp  <= ~w_dpv[w_idx_nxt];
    end
  end

  assign an       = r_an;
  assign segment  = r_seg;
  assign dp       = r_dp;
  assign scan_idx = r_idx;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: cycle model feeds a scoreboard queue, scenario tasks
// add targeted checks of the visible scan behaviour.
module tb_seg7_scan_driver;

  localparam int ND = 4;
  localparam int SD = 4;
  localparam int CW = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] digits = 16'h1234;
  logic [3:0]  dp_in = 4'h0;
  logic        hex_en = 1'b0;
  logic        blank_lz = 1'b0;
  logic        enable = 1'b1;
  logic [3:0]  an;
  logic [6:0]  segment;
  logic        dp;
  logic [1:0]  scan_idx;

  int total = 0;
  int bad = 0;

  seg7_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .digits(digits), .dp_in(dp_in), .hex_en(hex_en),
    .blank_lz(blank_lz), .enable(enable), .an(an), .segment(segment), .dp(dp),
    .scan_idx(scan_idx)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input logic [3:0] v, input logic hex);
    logic [6:0] tbl [16];
    tbl = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 7'b0100100,
            7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
            7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    if (v >= 4'd10 && !hex) return 7'b1111111;
    return tbl[v];
  endfunction

  // Reference model; {an, segment, dp, scan_idx} expected after each rising edge.
  logic [13:0] exp_q[$];
  int          m_cnt;
  int          m_idx;
  logic [15:0] m_dig;
  logic [3:0]  m_dp;
  logic        m_hex, m_blz, m_first, m_was_en;

  always @(negedge rst_n) exp_q.delete();

  always @(posedge clk) begin
    if (!rst_n) begin
      m_cnt = 0; m_idx = 0; m_dig = '0; m_dp = '0; m_hex = 0; m_blz = 0;
      m_first = 1; m_was_en = 1;
      exp_q.push_back({4'hF, 7'h7F, 1'b1, 2'd0});
    end else if (!enable) begin
      m_was_en = 0;
      exp_q.push_back({4'hF, 7'h7F, 1'b1, 2'(m_idx)});
    end else begin
      bit tick, blanked, lit;
      int nidx;
      logic [3:0] e_an;
      logic [6:0] e_seg;
      tick = (m_cnt == SD - 1);
      nidx = tick ? (m_idx + 1) % ND : m_idx;
      if (m_first || (tick && nidx == 0)) begin
        m_dig = digits; m_dp = dp_in; m_hex = hex_en; m_blz = blank_lz;
      end
      blanked = m_blz && nidx != 0 && ((m_dig >> (4 * nidx)) == 16'd0);
      lit     = !blanked || m_dp[nidx];
      e_seg   = blanked ? 7'h7F : seg_of(4'((m_dig >> (4 * nidx)) & 16'hF), m_hex);
      e_an    = (tick || !m_was_en || !lit) ? 4'hF : ~(4'b0001 << nidx);
      exp_q.push_back({e_an, e_seg, ~m_dp[nidx], 2'(nidx)});
      m_cnt = tick ? 0 : m_cnt + 1;
      m_idx = nidx; m_first = 0; m_was_en = 1;
    end
  end

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [13:0] e;
      e = exp_q.pop_front();
      total++;
      if ({an, segment, dp, scan_idx} !== e) begin
        bad++;
        $display("FAIL scoreboard t=%0t got an=%b seg=%b dp=%b idx=%0d want an=%b seg=%b dp=%b idx=%0d",
                 $time, an, segment, dp, scan_idx, e[13:10], e[9:3], e[2], e[1:0]);
      end
    end
  end

  task automatic wait_lit(input int k);
    logic [3:0] tgt;
    tgt = ~(4'b0001 << k);
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (an === tgt) return;
    end
    total++; bad++;
    $display("FAIL wait_lit digit=%0d timed out, an=%b required=%b", k, an, tgt);
  endtask

  task automatic next_frame();
    int n;
    n = 0;
    while (scan_idx == 2'd0 && n < 100) begin @(negedge clk); n++; end
    while (scan_idx != 2'd0 && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin
      total++; bad++;
      $display("FAIL next_frame timed out, idx=%0d required=0", scan_idx);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++;
    if ({an, segment, dp, scan_idx} !== {4'hF, 7'h7F, 1'b1, 2'd0}) begin
      bad++;
      $display("FAIL reset got an=%b seg=%b dp=%b idx=%0d required 1111/1111111/1/0",
               an, segment, dp, scan_idx);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_scan();
    logic [6:0] want [4];
    want = '{7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111};
    for (int k = 0; k < 4; k++) begin
      int n;
      wait_lit(k);
      total++;
      if (segment !== want[k]) begin
        bad++;
        $display("FAIL scan_seg digit=%0d got %b required %b", k, segment, want[k]);
      end
      n = 1;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (an === ~(4'b0001 << k)) n++;
        else break;
      end
      total++;
      if (n != 3 || an !== 4'hF) begin
        bad++;
        $display("FAIL scan_len digit=%0d lit=%0d next_an=%b required lit=3 next_an=1111",
                 k, n, an);
      end
    end
  endtask

  task automatic test_hex();
    @(negedge clk); digits = 16'h00A0; hex_en = 1'b1;
    next_frame(); wait_lit(1);
    total++;
    if (segment !== 7'b0001000) begin
      bad++; $display("FAIL hex_on got %b required 0001000", segment);
    end
    hex_en = 1'b0;
    next_frame(); wait_lit(1);
    total++;
    if (segment !== 7'b1111111) begin
      bad++; $display("FAIL hex_off got %b required 1111111", segment);
    end
  endtask

  task automatic test_blank();
    bit         upper_seen, other_seen, zero_seen;
    logic [6:0] s1, s0;
    @(negedge clk); blank_lz = 1'b1; digits = 16'h0050;
    next_frame();
    upper_seen = 0; s1 = 'x; s0 = 'x;
    for (int i = 0; i < 16; i++) begin
      if (an === 4'b0111 || an === 4'b1011) upper_seen = 1;
      if (an === 4'b1101) s1 = segment;
      if (an === 4'b1110) s0 = segment;
      @(negedge clk);
    end
    total++;
    if (upper_seen || s1 !== 7'b0100100 || s0 !== 7'b0000001) begin
      bad++;
      $display("FAIL blank_0050 upper=%0d s1=%b s0=%b required 0/0100100/0000001",
               upper_seen, s1, s0);
    end
    digits = 16'h0000;
    next_frame();
    other_seen = 0; zero_seen = 0;
    for (int i = 0; i < 16; i++) begin
      if (an !== 4'hF && an !== 4'b1110) other_seen = 1;
      if (an === 4'b1110 && segment === 7'b0000001) zero_seen = 1;
      @(negedge clk);
    end
    total++;
    if (other_seen || !zero_seen) begin
      bad++;
      $display("FAIL blank_0000 other_lit=%0d zero_shown=%0d required 0/1", other_seen, zero_seen);
    end
  endtask

  task automatic test_dp();
    @(negedge clk); digits = 16'h0007; dp_in = 4'b0100;
    next_frame(); wait_lit(2);
    total++;
    if (segment !== 7'h7F || dp !== 1'b0) begin
      bad++; $display("FAIL dp_blank got seg=%b dp=%b required 1111111/0", segment, dp);
    end
    dp_in = 4'b0000; blank_lz = 1'b0;
  endtask

  task automatic test_snapshot();
    @(negedge clk); digits = 16'h1111;
    next_frame(); wait_lit(2);
    digits = 16'h2222;
    wait_lit(3);
    total++;
    if (segment !== 7'b1001111) begin
      bad++; $display("FAIL snap_old got %b required 1001111", segment);
    end
    next_frame();
    for (int k = 0; k < 4; k++) begin
      wait_lit(k);
      total++;
      if (segment !== 7'b0010010) begin
        bad++; $display("FAIL snap_new digit=%0d got %b required 0010010", k, segment);
      end
    end
  endtask

  task automatic test_enable();
    logic [1:0] held;
    wait_lit(1);
    @(negedge clk);
    enable = 1'b0; held = scan_idx;
    @(negedge clk);
    total++;
    if ({an, segment, dp} !== {4'hF, 7'h7F, 1'b1} || scan_idx !== held) begin
      bad++;
      $display("FAIL disable got an=%b seg=%b dp=%b idx=%0d required 1111/1111111/1/%0d",
               an, segment, dp, scan_idx, held);
    end
    repeat (6) @(negedge clk);
    total++;
    if (scan_idx !== held) begin
      bad++; $display("FAIL frozen got idx=%0d required %0d", scan_idx, held);
    end
    enable = 1'b1;
    @(negedge clk);
    total++;
    if (an !== 4'hF || scan_idx !== held) begin
      bad++; $display("FAIL reenable got an=%b idx=%0d required 1111/%0d", an, scan_idx, held);
    end
  endtask

  task automatic test_async_reset();
    wait_lit(2);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({an, segment, dp, scan_idx} !== {4'hF, 7'h7F, 1'b1, 2'd0}) begin
      bad++;
      $display("FAIL async_reset got an=%b seg=%b dp=%b idx=%0d required 1111/1111111/1/0",
               an, segment, dp, scan_idx);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (an !== 4'b1110 || scan_idx !== 2'd0) begin
      bad++; $display("FAIL restart got an=%b idx=%0d required 1110/0", an, scan_idx);
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_hex();
    test_blank();
    test_dp();
    test_snapshot();
    test_enable();
    test_async_reset();
    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
